prim_onehot_rr_sched: RTL
=========================

# prim_onehot_rr_sched

Round-robin scheduler that shares one downstream resource among `N` requesters and drives the one-hot select for that resource. It picks a winner with a rotating priority pointer and registers the winner's index. It presents the index and its one-hot decode, gated by valid, to the consumer. It holds that grant stable until the consumer accepts it with a valid/ready handshake. It sits in front of the one-hot select / mux stages of the datapath that feed a shared port (bus master port, shared FIFO, shared register file port).

## Interface
Parameters:
- `N`, default 8: number of requesters; legal range 2..64, need not be a power of two.
- `IdxW`, default `$clog2(N)`: localparam, width of the index output.

Ports:
- `clk_i`  in  1: clock; all state updates on rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `req_i`  in  N: request vector; bit i high means requester i wants the resource.
- `ready_i`  in  1: consumer accepts the current grant this cycle.
- `valid_o`  out  1: a grant is being presented.
- `idx_o`  out  IdxW: index of the granted requester.
- `gnt_o`  out  N: one-hot grant; `gnt_o[i] = valid_o & (idx_o == i)`; all-zero when `valid_o` is low.
- `lock_i`  in  N: per-requester lock; present only with `PRIM_ONEHOT_SCHED_LOCK_EN`.

## Operation
- Internal state: FSM `{IDLE, GRANT}`, priority pointer `ptr_q` (IdxW bits, range 0..N-1), registered index `idx_q`.
- Arbitration function `arb(req, start)` returns the first set bit of `req` scanning i = start, start+1, …, N-1, 0, …, start-1.
- IDLE:
  - `valid_o` = 0.
  - If `|req_i`: `idx_q <= arb(req_i, ptr_q)` and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `valid_o` = 1 and `idx_o` = `idx_q`.
  - While `ready_i` = 0, `idx_q`, `ptr_q` and the state are frozen, regardless of `req_i` changes. This includes the granted requester dropping its request: the grant is held until accepted.
  - Handshake (`valid_o & ready_i`) sets `ptr_q <= idx_q + 1`, wrapping N-1 → 0 explicitly, not by modulo-2^IdxW.
  - Back-to-back: on a handshake cycle, let `req_nxt = req_i & ~(1 << idx_q)`.
    - If `|req_nxt`: `idx_q <= arb(req_nxt, idx_q+1 wrapped)` and stay in GRANT.
    - Else: go to IDLE.
  - The just-served requester is excluded for one decision, so a lone continuous requester alternates GRANT, IDLE, GRANT.
- Fairness: any requester holding `req_i` high is granted within N handshakes.
- Unused index codes (N not a power of two) are never produced.

## Timing
- Reset values: `valid_o` = 0, `gnt_o` = 0, `idx_o` = 0, `ptr_q` = 0, state IDLE.
- Assertion of `rst_ni` low mid-grant clears all outputs asynchronously. After deassertion, arbitration restarts from pointer 0.
- Latency: a request sampled at edge k in IDLE gives `valid_o`/`gnt_o` high after edge k (1 cycle).
- Outputs are purely registered (`gnt_o` is a decode of registered state only). There is no combinational path from `req_i` or `ready_i` to any output.
- Throughput: one grant per cycle while at least two requesters are active; one grant per two cycles with a single requester.
- `ready_i` is ignored while `valid_o` = 0.

## Configuration
- `PRIM_ONEHOT_SCHED_LOCK_EN` defined:
  - `lock_i` port exists.
  - On a handshake with `lock_i[idx_q]` = 1 and `req_i[idx_q]` = 1: `idx_q` is unchanged, the state stays GRANT and `ptr_q` is not advanced. The same requester is granted again on the next cycle (atomic burst).
  - With `lock_i[idx_q]` = 0: normal rotation.
  - A lock held by a requester whose request has dropped has no effect.
- Not defined:
  - `lock_i` port is absent.
  - Rotation always applies; the behaviour is identical to the enabled build with `lock_i` tied to 0.

## Test plan
- Reset and idle: hold `rst_ni` low, then release with `req_i` = 0 → `valid_o`/`gnt_o`/`idx_o` stay 0 for 10 cycles.
- Rotation: N=8, `req_i` = 0xFF, `ready_i` = 1 → `idx_o` sequence 0,1,…,7,0 on consecutive cycles, and `gnt_o` = 1<<idx each cycle.
- Backpressure: `req_i` = 0x24, `ready_i` = 0 for 5 cycles, `req_i` changed to 0x01 mid-stall → `idx_o` = 2 is held; after `ready_i` = 1, `ptr_q` = 3, and the next grant is 0 one cycle later.
- Wrap with non-power-of-2: N=5, `req_i` = 0x11, `ready_i` = 1 → `idx_o` alternates 4,0,4,0 and never exceeds 4.
- Single requester: `req_i` = 0x08 held, `ready_i` = 1 → `valid_o` pattern 1,0,1,0 with `idx_o` = 3.
- Lock (macro on): `req_i` = 0x06, `lock_i` = 0x02 for 3 handshakes → `idx_o` = 1,1,1. Lock released → next grant `idx_o` = 2. Same stimulus with macro off → `idx_o` = 1,2,1,2.

Source files
------------

// File: rtl/prim_onehot_rr_sched.sv
// prim_onehot_rr_sched: round-robin scheduler for a shared resource.
// A rotating priority pointer picks a winner. The winner's index is
// registered and held as a valid/ready grant, together with its one-hot
// decode, until the consumer accepts it.
// Optional feature macro: PRIM_ONEHOT_SCHED_LOCK_EN adds the lock_i port.
// A locked, still-requesting winner is re-granted on a handshake
// (atomic burst).

module prim_onehot_rr_sched #(
  parameter  int N    = 8,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            ready_i,
`ifdef PRIM_ONEHOT_SCHED_LOCK_EN
  input  logic [N-1:0]    lock_i,
`endif
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o,
  output logic [N-1:0]    gnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   idx_q;

  logic [N-1:0]      req_nxt;
  logic [IdxW-1:0]   ptr_nxt;
  logic              hold;

  // First set bit of req, scanning upward from start and wrapping at N-1.
  // The wrap is at N, not 2^IdxW, so unused codes are never returned.
  function automatic logic [IdxW-1:0] arb(input logic [N-1:0]    req,
                                          input logic [IdxW-1:0] start);
    logic [IdxW-1:0] res;
    logic            found;
    int unsigned     pos;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[IdxW'(pos)]) begin
        res   = IdxW'(pos);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Successor index with an explicit N-1 -> 0 wrap.
  function automatic logic [IdxW-1:0] inc(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(N - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Handshake helpers: drop the just-served requester, compute the next
  // pointer, and decide whether a lock pins the grant.
  always_comb begin
    req_nxt = req_i & ~(N'(1) << idx_q);
    ptr_nxt = inc(idx_q);
    hold    = 1'b0;
`ifdef PRIM_ONEHOT_SCHED_LOCK_EN
    hold    = lock_i[idx_q] & req_i[idx_q];
`endif
  end

  // Scheduler FSM. The grant is frozen while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            idx_q   <= arb(req_i, ptr_q);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (ready_i && !hold) begin
            ptr_q <= ptr_nxt;
            if (|req_nxt) begin
              idx_q <= arb(req_nxt, ptr_nxt);
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Outputs decode registered state only. No combinational path exists
  // from req_i or ready_i to the outputs.
  always_comb begin
    valid_o = (state_q == GRANT);
    idx_o   = valid_o ? idx_q : '0;
    gnt_o   = valid_o ? (N'(1) << idx_q) : '0;
  end

endmodule
